intrude_host_if: RTL and testbench

- Host-side front end for the intrusion path. Sits directly upstream of the intrusion cycle sequencer and produces the RD, WR and TRUDY requests that the sequencer consumes.
- Converts asynchronous host parallel-port strobes into single, clean intrusion cycles.
- Holds the 20-bit intrusion address, latches write data and captures read data.
- Returns a level handshake (HACK) to the host.

---
 rtl/intrude_pkg.sv | 22 ++
 rtl/intrude_sync.sv | 37 +++
 rtl/intrude_host_if.sv | 180 ++++++++++++++++++
 tb/tb_intrude_host_if.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intrude_pkg.sv
// Shared definitions for the host intrusion front end.
//   state_t      : host interface FSM states
//   SEL_*        : HSEL register-select codes
//   DEF_ADDR_W   : default intrusion address width
package intrude_pkg;

  localparam int DEF_ADDR_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOCAL,
    REQ,
    ACCESS,
    ACK
  } state_t;

  localparam logic [1:0] SEL_ALO  = 2'd0;  // addr[7:0]
  localparam logic [1:0] SEL_AMID = 2'd1;  // addr[15:8]
  localparam logic [1:0] SEL_AHI  = 2'd2;  // addr[ADDR_W-1:16]
  localparam logic [1:0] SEL_DATA = 2'd3;  // intrusion data cycle

endpackage

// File: rtl/intrude_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clk    : destination clock
//   reset  : synchronous, active-high; flops load INIT
//   d      : asynchronous input
//   level  : synchronised level
//   fall   : one-cycle pulse on a synchronised 1->0 transition
// STAGES must be at least 2.
module intrude_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: flops reset to the input's idle level, so leaving reset never
  // looks like an edge to the logic downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{INIT}};
      prev_q <= INIT;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign fall  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/intrude_host_if.sv
// Host parallel-port front end for the intrusion path.
// Turns asynchronous host strobes into single intrusion cycles for the
// downstream sequencer and returns a level handshake to the host.
//   CLK, RESET      : clock, synchronous active-high reset
//   HSTB_N          : async active-low host strobe
//   HRW, HSEL, HDI  : host direction (1=read), register select, write data
//   HDO, HACK, ERR  : host read data, handshake, sticky timeout flag
//   TRUDY, RD, WR   : intrusion requests to the sequencer
//   GRANT, DONE     : sequencer bus grant, cycle-complete pulse
//   ADDR, DOUT, DIN : intrusion address, write data, read data
module intrude_host_if
  import intrude_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,  // 17..24
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HSTB_N,
  input  logic              HRW,
  input  logic [1:0]        HSEL,
  input  logic [7:0]        HDI,
  output logic [7:0]        HDO,
  output logic              HACK,
  output logic              ERR,
  output logic              TRUDY,
  output logic              RD,
  output logic              WR,
  input  logic              GRANT,
  input  logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [7:0]        DOUT,
  input  logic [7:0]        DIN
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Counter value during the last permitted REQ/ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             rw_q;
  logic [1:0]       sel_q;
  logic [7:0]       hdi_q;
  logic [CNT_W-1:0] cnt;
  logic             stb_level;
  logic             stb_fall;

  intrude_sync #(
    .STAGES(SYNC_STAGES),
    .INIT  (1'b1)
  ) u_stb_sync (
    .clk  (CLK),
    .reset(RESET),
    .d    (HSTB_N),
    .level(stb_level),
    .fall (stb_fall)
  );

  // Address bytes are handled through a 24-bit zero-padded view so the
  // top byte naturally drops bits above ADDR_W and reads back zero-extended.
  function automatic logic [ADDR_W-1:0] put_byte(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        s,
                                                  input logic [7:0]        b);
    logic [23:0] ext;
    ext = 24'(a);
    case (s)
      SEL_ALO:  ext[7:0]   = b;
      SEL_AMID: ext[15:8]  = b;
      default:  ext[23:16] = b;
    endcase
    return ext[ADDR_W-1:0];
  endfunction

  function automatic logic [7:0] get_byte(input logic [ADDR_W-1:0] a,
                                          input logic [1:0]        s);
    logic [23:0] ext;
    ext = 24'(a);
    case (s)
      SEL_ALO:  return ext[7:0];
      SEL_AMID: return ext[15:8];
      default:  return ext[23:16];
    endcase
  endfunction

  // NOTE: all state and outputs are registered with non-blocking assignments;
  // each output is written only on state transitions so it stays glitch-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      rw_q  <= 1'b0;
      sel_q <= SEL_ALO;
      hdi_q <= '0;
      cnt   <= '0;
      ADDR  <= '0;
      DOUT  <= '0;
      HDO   <= '0;
      HACK  <= 1'b0;
      ERR   <= 1'b0;
      TRUDY <= 1'b0;
      RD    <= 1'b0;
      WR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stb_fall) begin
            rw_q  <= HRW;
            sel_q <= HSEL;
            hdi_q <= HDI;
            ERR   <= 1'b0;
            if (HSEL != SEL_DATA) begin
              state <= LOCAL;
            end else begin
              if (!HRW) DOUT <= HDI;
              cnt   <= '0;
              TRUDY <= 1'b1;
              RD    <= HRW;
              WR    <= ~HRW;
              state <= REQ;
            end
          end
        end

        LOCAL: begin
          if (rw_q) HDO  <= get_byte(ADDR, sel_q);
          else      ADDR <= put_byte(ADDR, sel_q, hdi_q);
          HACK  <= 1'b1;
          state <= ACK;
        end

        REQ: begin
          // DONE is deliberately not looked at here, even alongside GRANT.
          if (cnt == CNT_LAST) begin
            ERR   <= 1'b1;
            TRUDY <= 1'b0;
            RD    <= 1'b0;
            WR    <= 1'b0;
            HACK  <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (GRANT) state <= ACCESS;
          end
        end

        ACCESS: begin
          // DONE takes priority over a timeout falling in the same cycle.
          if (DONE) begin
            if (rw_q) HDO <= DIN;
            ADDR  <= ADDR + ADDR_W'(1);
            TRUDY <= 1'b0;
            RD    <= 1'b0;
            WR    <= 1'b0;
            HACK  <= 1'b1;
            state <= ACK;
          end else if (cnt == CNT_LAST) begin
            ERR   <= 1'b1;
            TRUDY <= 1'b0;
            RD    <= 1'b0;
            WR    <= 1'b0;
            HACK  <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ACK: begin
          if (stb_level) begin
            HACK  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intrude_host_if.sv
// Self-checking bench for intrude_host_if: drives host strobes, plays the
// sequencer (GRANT/DONE) and scores the completed host accesses.
module tb_intrude_host_if;
  import intrude_pkg::*;

  localparam int ADDR_W      = 20;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;
  localparam int LOCAL_LAT   = SYNC_STAGES + 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              HSTB_N;
  logic              HRW;
  logic [1:0]        HSEL;
  logic [7:0]        HDI;
  logic [7:0]        HDO;
  logic              HACK;
  logic              ERR;
  logic              TRUDY;
  logic              RD;
  logic              WR;
  logic              GRANT;
  logic              DONE;
  logic [ADDR_W-1:0] ADDR;
  logic [7:0]        DOUT;
  logic [7:0]        DIN;

  intrude_host_if #(
    .ADDR_W     (ADDR_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .HSTB_N(HSTB_N),
    .HRW   (HRW),
    .HSEL  (HSEL),
    .HDI   (HDI),
    .HDO   (HDO),
    .HACK  (HACK),
    .ERR   (ERR),
    .TRUDY (TRUDY),
    .RD    (RD),
    .WR    (WR),
    .GRANT (GRANT),
    .DONE  (DONE),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .DIN   (DIN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]        hdo;
    logic [ADDR_W-1:0] addr;
    logic              err;
    int                trudy_cycles;  // cycles TRUDY is seen high
    int                latency;       // strobe-to-HACK edges, -1 = don't care
  } exp_t;

  exp_t sb[$];

  // Reference model of the host-visible registers.
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_hdo;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic err, input int tc, input int lat);
    exp_t e;
    e.hdo          = m_hdo;
    e.addr         = m_addr;
    e.err          = err;
    e.trudy_cycles = tc;
    e.latency      = lat;
    sb.push_back(e);
  endtask

  // One host access with the bench acting as sequencer. grant_at/done_at/
  // extra_done_at index the TRUDY-high cycles (0 = first); -1 = never.
  task automatic do_access(input string name, input logic rw,
                           input logic [1:0] sel, input logic [7:0] hdi,
                           input int grant_at, input int done_at,
                           input int extra_done_at, input logic [7:0] din);
    exp_t e;
    int   cyc;
    int   tcnt;
    logic bad_req;
    cyc     = 0;
    tcnt    = 0;
    bad_req = 1'b0;
    HRW     = rw;
    HSEL    = sel;
    HDI     = hdi;
    DIN     = din;
    HSTB_N  = 1'b0;
    while (!HACK && cyc < 2000) begin
      tick();
      cyc++;
      GRANT = 1'b0;
      DONE  = 1'b0;
      if ((RD && WR) || ((RD || WR) && !TRUDY)) bad_req = 1'b1;
      if (TRUDY) begin
        if (RD !== rw || WR !== ~rw) bad_req = 1'b1;
        if (tcnt == grant_at) GRANT = 1'b1;
        if (tcnt == done_at || tcnt == extra_done_at) DONE = 1'b1;
        tcnt++;
      end
    end
    GRANT = 1'b0;
    DONE  = 1'b0;

    checks++;
    if (HACK !== 1'b1) begin
      errors++;
      $display("FAIL %s hack_timeout: HACK=%b after %0d cycles, need 1", name, HACK, cyc);
    end
    checks++;
    if (bad_req) begin
      errors++;
      $display("FAIL %s rd_wr_rules: illegal RD/WR/TRUDY combination seen, need none", name);
    end
    checks++;
    if (TRUDY !== 1'b0 || RD !== 1'b0 || WR !== 1'b0) begin
      errors++;
      $display("FAIL %s req_drop: TRUDY=%b RD=%b WR=%b with HACK, need 000", name, TRUDY, RD, WR);
    end

    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got 0 entries, need 1", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (HDO !== e.hdo) begin
        errors++;
        $display("FAIL %s hdo: got %h need %h", name, HDO, e.hdo);
      end
      checks++;
      if (ADDR !== e.addr) begin
        errors++;
        $display("FAIL %s addr: got %h need %h", name, ADDR, e.addr);
      end
      checks++;
      if (ERR !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b need %b", name, ERR, e.err);
      end
      checks++;
      if (tcnt != e.trudy_cycles) begin
        errors++;
        $display("FAIL %s trudy_cycles: got %0d need %0d", name, tcnt, e.trudy_cycles);
      end
      if (e.latency >= 0) begin
        checks++;
        if (cyc != e.latency) begin
          errors++;
          $display("FAIL %s latency: got %0d need %0d", name, cyc, e.latency);
        end
      end
      // HACK and HDO must hold while the host keeps the strobe low.
      tick();
      tick();
      checks++;
      if (HACK !== 1'b1 || HDO !== e.hdo) begin
        errors++;
        $display("FAIL %s hack_hold: HACK=%b HDO=%h need 1 %h", name, HACK, HDO, e.hdo);
      end
    end

    HSTB_N = 1'b1;
    cyc    = 0;
    while (HACK && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (HACK !== 1'b0) begin
      errors++;
      $display("FAIL %s hack_release: HACK=%b need 0", name, HACK);
    end
    tick();
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    HSTB_N = 1'b1;
    HRW    = 1'b0;
    HSEL   = SEL_ALO;
    HDI    = '0;
    GRANT  = 1'b0;
    DONE   = 1'b0;
    DIN    = '0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    checks++;
    if ({ADDR, DOUT, HDO, HACK, ERR, TRUDY, RD, WR} !== '0) begin
      errors++;
      $display("FAIL reset_state: ADDR=%h DOUT=%h HDO=%h HACK=%b ERR=%b TRUDY=%b RD=%b WR=%b need all 0",
               ADDR, DOUT, HDO, HACK, ERR, TRUDY, RD, WR);
    end
    // GRANT/DONE while idle must be ignored.
    GRANT = 1'b1;
    DONE  = 1'b1;
    tick();
    GRANT = 1'b0;
    DONE  = 1'b0;
    tick();
    checks++;
    if (ADDR !== '0 || TRUDY !== 1'b0 || HACK !== 1'b0) begin
      errors++;
      $display("FAIL idle_done_ignored: ADDR=%h TRUDY=%b HACK=%b need 0 0 0", ADDR, TRUDY, HACK);
    end
    m_addr = '0;
    m_hdo  = '0;
  endtask

  task automatic test_addr_load();
    m_addr[7:0] = 8'h34;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("load_alo", 1'b0, SEL_ALO, 8'h34, -1, -1, -1, 8'h00);
    m_addr[15:8] = 8'h12;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("load_amid", 1'b0, SEL_AMID, 8'h12, -1, -1, -1, 8'h00);
    m_addr[19:16] = 4'hA;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("load_ahi", 1'b0, SEL_AHI, 8'h0A, -1, -1, -1, 8'h00);
    m_hdo = 8'h0A;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("read_ahi", 1'b1, SEL_AHI, 8'hEE, -1, -1, -1, 8'h00);
    m_hdo = 8'h12;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("read_amid", 1'b1, SEL_AMID, 8'hEE, -1, -1, -1, 8'h00);
  endtask

  task automatic test_data_write();
    m_addr = m_addr + 1'b1;
    push_exp(1'b0, 6, -1);
    do_access("data_write", 1'b0, SEL_DATA, 8'h5A, 3, 5, -1, 8'h00);
    checks++;
    if (DOUT !== 8'h5A) begin
      errors++;
      $display("FAIL data_write_dout: got %h need 5a", DOUT);
    end
  endtask

  task automatic test_data_read_wrap();
    m_addr[7:0] = 8'hFF;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("wrap_alo", 1'b0, SEL_ALO, 8'hFF, -1, -1, -1, 8'h00);
    m_addr[15:8] = 8'hFF;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("wrap_amid", 1'b0, SEL_AMID, 8'hFF, -1, -1, -1, 8'h00);
    m_addr[19:16] = 4'hF;  // upper four bits of the byte are discarded
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("wrap_ahi", 1'b0, SEL_AHI, 8'hFF, -1, -1, -1, 8'h00);
    m_hdo = 8'h0F;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("wrap_ahi_read", 1'b1, SEL_AHI, 8'h00, -1, -1, -1, 8'h00);
    m_hdo  = 8'hC3;
    m_addr = '0;
    push_exp(1'b0, 5, -1);
    do_access("read_wrap", 1'b1, SEL_DATA, 8'h00, 2, 4, -1, 8'hC3);
  endtask

  task automatic test_timeout();
    push_exp(1'b1, TIMEOUT, -1);
    do_access("timeout", 1'b1, SEL_DATA, 8'h00, -1, -1, -1, 8'h99);
    m_hdo = m_addr[7:0];
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("err_clear", 1'b1, SEL_ALO, 8'h00, -1, -1, -1, 8'h00);
  endtask

  task automatic test_grant_done_same();
    m_addr = m_addr + 1'b1;
    push_exp(1'b0, 5, -1);
    do_access("grant_done_same", 1'b0, SEL_DATA, 8'h77, 1, 1, 4, 8'h00);
  endtask

  task automatic test_collision();
    m_addr = m_addr + 1'b1;
    m_hdo  = 8'h3C;
    push_exp(1'b0, TIMEOUT, -1);
    do_access("done_timeout_collision", 1'b1, SEL_DATA, 8'h00, 0, TIMEOUT - 1, -1, 8'h3C);
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    HRW    = 1'b0;
    HSEL   = SEL_DATA;
    HDI    = 8'hA5;
    HSTB_N = 1'b0;
    cyc    = 0;
    while (!TRUDY && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (TRUDY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_trudy: TRUDY=%b need 1", TRUDY);
    end
    GRANT = 1'b1;
    tick();
    GRANT = 1'b0;
    tick();
    RESET  = 1'b1;
    HSTB_N = 1'b1;
    tick();
    RESET = 1'b0;
    checks++;
    if ({TRUDY, RD, WR, HACK} !== 4'b0000 || ADDR !== '0 || DOUT !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: TRUDY=%b RD=%b WR=%b HACK=%b ADDR=%h DOUT=%h need all 0",
               TRUDY, RD, WR, HACK, ADDR, DOUT);
    end
    repeat (5) tick();
    checks++;
    if (HACK !== 1'b0 || TRUDY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: HACK=%b TRUDY=%b need 0 0", HACK, TRUDY);
    end
    m_addr = '0;
    m_hdo  = '0;
    m_addr[7:0] = 8'h5C;
    push_exp(1'b0, 0, LOCAL_LAT);
    do_access("after_reset", 1'b0, SEL_ALO, 8'h5C, -1, -1, -1, 8'h00);
  endtask

  initial begin
    test_reset();
    test_addr_load();
    test_data_write();
    test_data_read_wrap();
    test_timeout();
    test_grant_done_same();
    test_collision();
    test_reset_mid_access();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
